// File: rtl/output_bcd_display_if.sv
// -----------------------------------------------------------------------------
// output_bcd_display_if
//   Bundle of the request/response and display signals of output_bcd_display.
//
//   Handshake: the master raises start with binario/signed_mode valid; the
//   slave accepts on a rising edge only while it is idle (busy=0), and from the
//   next cycle on raises busy. A start seen while busy is dropped, not queued.
//   When the result is ready the slave lowers busy and pulses done for exactly
//   one cycle; segmentos/sinal/overflow are valid from that cycle on and hold
//   until the next done.
//
//   Signals
//     start        master->slave  conversion request
//     binario      master->slave  WIDTH-bit operand
//     signed_mode  master->slave  treat binario as two's complement
//     busy         slave->master  conversion in progress
//     done         slave->master  one-cycle result-valid pulse
//     overflow     slave->master  last magnitude exceeded 10^DIGITS-1
//     segmentos    slave->master  DIGITS x 7 segment patterns, digit 0 at LSBs
//     sinal        slave->master  sign digit (minus or blank)
// -----------------------------------------------------------------------------
interface output_bcd_display_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      binario;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   segmentos;
  logic [6:0]            sinal;

  modport master (
    output start, binario, signed_mode,
    input  busy, done, overflow, segmentos, sinal
  );

  modport slave (
    input  start, binario, signed_mode,
    output busy, done, overflow, segmentos, sinal
  );
endinterface

// File: rtl/output_bcd_display.sv
// -----------------------------------------------------------------------------
// output_bcd_display
//   Iterative binary-to-decimal seven-segment display driver. An operand is
//   accepted on start, converted by double-dabble one bit per clock, and the
//   resulting digits are registered with leading-zero blanking, a sign digit
//   and overflow dashes.
//
//   Ports
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      output_bcd_display_if.slave (start/operand in, display out)
//     o_state  current FSM state (0 IDLE, 1 CONV, 2 LOAD) for observation
//
//   Parameters
//     WIDTH        operand width (>= 4)
//     DIGITS       number of decimal digits (>= 1)
//     ACTIVE_LOW   1: lit segment driven 0
//     BLANK_ZEROS  1: blank leading zero digits (digit 0 always shown)
// -----------------------------------------------------------------------------
module output_bcd_display #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output_bcd_display_if.slave   bus,
  output logic [1:0]            o_state
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [6:0] SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;  // segment g only, active-high

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t                r_state;
  logic [BCDW-1:0]       r_bcd;
  logic [WIDTH-1:0]      r_mag;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic                  r_ovf_sticky;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [7*DIGITS-1:0]   r_seg;
  logic [6:0]            r_sinal;

  logic [WIDTH-1:0]      w_mag_in;
  logic                  w_neg_in;
  logic [BCDW-1:0]       w_bcd_adj;
  logic [BCDW-1:0]       w_bcd_next;
  logic [WIDTH-1:0]      w_mag_next;
  logic                  w_carry_out;
  logic [DIGITS-1:0]     w_upper_nz;
  logic [7*DIGITS-1:0]   w_seg_load;
  logic [6:0]            w_sinal_load;

  // Active-high segment pattern for a BCD digit, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0:    enc_digit = 7'h3F;
      4'd1:    enc_digit = 7'h06;
      4'd2:    enc_digit = 7'h5B;
      4'd3:    enc_digit = 7'h4F;
      4'd4:    enc_digit = 7'h66;
      4'd5:    enc_digit = 7'h6D;
      4'd6:    enc_digit = 7'h7D;
      4'd7:    enc_digit = 7'h07;
      4'd8:    enc_digit = 7'h7F;
      4'd9:    enc_digit = 7'h6F;
      default: enc_digit = 7'h00;
    endcase
  endfunction

  // Map an active-high pattern to the physical segment polarity.
  function automatic logic [6:0] drive(input logic [6:0] p);
    drive = (ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // Operand capture: two's complement negate when the sign bit is set in
  // signed mode. The most-negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1).
  assign w_neg_in = bus.signed_mode & bus.binario[WIDTH-1];
  assign w_mag_in = w_neg_in ? ((~bus.binario) + WIDTH'(1)) : bus.binario;

  // Double-dabble correction: any digit >= 5 gets +3 so the following shift
  // carries correctly into the next decade.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // One-bit left shift of {BCD, magnitude}; the bit leaving the top digit
  // means the value no longer fits in DIGITS decimal digits.
  assign {w_carry_out, w_bcd_next, w_mag_next} = {w_bcd_adj, r_mag, 1'b0};

  // w_upper_nz[i]: some digit at position >= i is nonzero. A digit is shown
  // when it or any higher digit is nonzero, or it is the units digit.
  always_comb begin
    w_upper_nz = '0;
    w_upper_nz[DIGITS-1] = (r_bcd[4*(DIGITS-1) +: 4] != 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_upper_nz[i] = w_upper_nz[i+1] | (r_bcd[4*i +: 4] != 4'd0);
    end
  end

  always_comb begin
    w_seg_load = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_ovf_sticky) begin
        w_seg_load[7*i +: 7] = drive(SEG_DASH);
      end else if ((BLANK_ZEROS == 0) || (i == 0) || w_upper_nz[i]) begin
        w_seg_load[7*i +: 7] = drive(enc_digit(r_bcd[4*i +: 4]));
      end else begin
        w_seg_load[7*i +: 7] = SEG_OFF;
      end
    end
  end

  // r_neg is only ever set for a nonzero magnitude (a negative operand never
  // negates to zero), so it alone decides the minus sign.
  assign w_sinal_load = r_neg ? drive(SEG_DASH) : SEG_OFF;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_bcd        <= '0;
      r_mag        <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_seg        <= {DIGITS{SEG_OFF}};
      r_sinal      <= SEG_OFF;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mag        <= w_mag_in;
            r_neg        <= w_neg_in;
            r_bcd        <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_next;
          r_mag <= w_mag_next;
          if (w_carry_out) begin
            r_ovf_sticky <= 1'b1;
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_seg      <= w_seg_load;
          r_sinal    <= w_sinal_load;
          r_overflow <= r_ovf_sticky;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;
  assign bus.segmentos = r_seg;
  assign bus.sinal     = r_sinal;
  assign o_state       = r_state;

endmodule

// File: tb/tb_output_bcd_display.sv
module tb_output_bcd_display;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] binario;
  logic        sm;
  logic [1:0]  st_a, st_b, st_c;

  int n_checks = 0;
  int n_fail   = 0;

  // a: active-high, blanking; b: active-high, no blanking; c: active-low, blanking
  output_bcd_display_if #(.WIDTH(32), .DIGITS(8)) bus_a ();
  output_bcd_display_if #(.WIDTH(32), .DIGITS(8)) bus_b ();
  output_bcd_display_if #(.WIDTH(32), .DIGITS(8)) bus_c ();

  assign bus_a.start = start;  assign bus_a.binario = binario;  assign bus_a.signed_mode = sm;
  assign bus_b.start = start;  assign bus_b.binario = binario;  assign bus_b.signed_mode = sm;
  assign bus_c.start = start;  assign bus_c.binario = binario;  assign bus_c.signed_mode = sm;

  output_bcd_display #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(0), .BLANK_ZEROS(1)) u_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a), .o_state(st_a));
  output_bcd_display #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(0), .BLANK_ZEROS(0)) u_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b), .o_state(st_b));
  output_bcd_display #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(1), .BLANK_ZEROS(1)) u_c (
    .clock(clock), .reset_n(reset_n), .bus(bus_c), .o_state(st_c));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] b;
    logic        sm;
    logic [55:0] segs;
    logic        ovf;
    logic [6:0]  sgn;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the magnitude.
  function automatic longint model_mag(input logic [31:0] b, input logic s);
    if (s && b[31]) model_mag = 64'h1_0000_0000 - longint'({32'd0, b});
    else            model_mag = longint'({32'd0, b});
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'h3F;  1: seg_of = 7'h06;  2: seg_of = 7'h5B;  3: seg_of = 7'h4F;
      4: seg_of = 7'h66;  5: seg_of = 7'h6D;  6: seg_of = 7'h7D;  7: seg_of = 7'h07;
      8: seg_of = 7'h7F;  default: seg_of = 7'h6F;
    endcase
  endfunction

  function automatic logic [55:0] model_segs(input logic [31:0] b, input logic s,
                                             input bit al, input bit bz);
    longint mag, p10;
    logic [6:0] p;
    logic [55:0] r;
    mag = model_mag(b, s);
    r = '0;
    p10 = 1;
    for (int i = 0; i < 8; i++) begin
      if (mag > 64'd99999999)            p = 7'h40;
      else if (bz && i > 0 && mag < p10) p = 7'h00;
      else                               p = seg_of(int'((mag / p10) % 10));
      r[7*i +: 7] = al ? ~p : p;
      p10 = p10 * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] model_sinal(input logic [31:0] b, input logic s, input bit al);
    logic [6:0] p;
    p = (s && b[31] && model_mag(b, s) != 0) ? 7'h40 : 7'h00;
    return al ? ~p : p;
  endfunction

  // driver: one accepted conversion, returns edges from accept to done
  task automatic run_conv(input logic [31:0] b, input logic s, output int lat, output int busy_cnt);
    @(negedge clock);
    start = 1'b1; binario = b; sm = s;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = bus_a.busy ? 1 : 0;
    while (!bus_a.done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (bus_a.busy) busy_cnt++;
    end
  endtask

  task automatic check_all(input logic [31:0] b, input logic s);
    chk("seg_a", bus_a.segmentos, model_segs(b, s, 0, 1));
    chk("seg_b", bus_b.segmentos, model_segs(b, s, 0, 0));
    chk("seg_c", bus_c.segmentos, model_segs(b, s, 1, 1));
    chk("ovf",   bus_a.overflow,  model_mag(b, s) > 64'd99999999);
    chk("ovf_c", bus_c.overflow,  model_mag(b, s) > 64'd99999999);
    chk("sin_a", bus_a.sinal,     model_sinal(b, s, 0));
    chk("sin_c", bus_c.sinal,     model_sinal(b, s, 1));
  endtask

  initial begin
    int lat, bcnt, dones, done_at, t1, t2, cyc;
    logic [31:0] rb;
    logic        rs;
    logic [55:0] seg_12345678;

    seg_12345678 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
    tbl[0] = '{32'd12345678,  1'b0, seg_12345678,                  1'b0, 7'h00};
    tbl[1] = '{32'd99999999,  1'b0, {8{7'h6F}},                    1'b0, 7'h00};
    tbl[2] = '{32'd100000000, 1'b0, {8{7'h40}},                    1'b1, 7'h00};
    tbl[3] = '{32'hFFFFFFFF,  1'b1, {{7{7'h00}}, 7'h06},           1'b0, 7'h40};
    tbl[4] = '{32'hFFFFFFFF,  1'b0, {8{7'h40}},                    1'b1, 7'h00};
    tbl[5] = '{32'd0,         1'b0, {{7{7'h00}}, 7'h3F},           1'b0, 7'h00};
    tbl[6] = '{32'h80000000,  1'b1, {8{7'h40}},                    1'b1, 7'h40};
    tbl[7] = '{32'd5,         1'b0, {{7{7'h00}}, 7'h6D},           1'b0, 7'h00};

    start = 1'b0; binario = '0; sm = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",  bus_a.busy, 1'b0);
    chk("rst_done",  bus_a.done, 1'b0);
    chk("rst_ovf",   bus_a.overflow, 1'b0);
    chk("rst_seg_a", bus_a.segmentos, 56'd0);
    chk("rst_seg_c", bus_c.segmentos, {56{1'b1}});
    chk("rst_sin_c", bus_c.sinal, 7'h7F);
    chk("rst_state", st_a, 2'd0);
    @(negedge clock); reset_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].b, tbl[i].sm, lat, bcnt);
      chk("latency",  lat, 33);
      chk("busy_len", bcnt, 33);
      chk("tbl_seg",  bus_a.segmentos, tbl[i].segs);
      chk("tbl_ovf",  bus_a.overflow, tbl[i].ovf);
      chk("tbl_sin",  bus_a.sinal, tbl[i].sgn);
      check_all(tbl[i].b, tbl[i].sm);
    end

    // zero with and without blanking, and active-low
    run_conv(32'd0, 1'b0, lat, bcnt);
    chk("zero_b", bus_b.segmentos, {8{7'h3F}});
    chk("zero_c", bus_c.segmentos, {{7{7'h7F}}, 7'h40});
    chk("zero_sin_c", bus_c.sinal, 7'h7F);
    @(posedge clock); #1;
    chk("done_pulse", bus_a.done, 1'b0);

    // starts during a conversion are ignored; operand changes have no effect
    @(negedge clock);
    start = 1'b1; binario = 32'd12345678; sm = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    bcnt = bus_a.busy ? 1 : 0;
    dones = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5 || c == 20) begin
        @(negedge clock); start = 1'b1; binario = 32'd1;
        @(posedge clock); #1; start = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
      if (bus_a.busy) bcnt++;
      if (bus_a.done) begin
        dones++;
        if (dones == 1) done_at = c;
      end
    end
    chk("ign_dones", dones, 1);
    chk("ign_done_at", done_at, 33);
    chk("ign_busy", bcnt, 33);
    chk("ign_hold_seg", bus_a.segmentos, seg_12345678);

    // reset in the middle of a conversion
    run_conv(32'd100000000, 1'b0, lat, bcnt);
    chk("pre_rst_ovf", bus_a.overflow, 1'b1);
    @(negedge clock);
    start = 1'b1; binario = 32'd12345678; sm = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus_a.busy, 1'b0);
    chk("mid_rst_done", bus_a.done, 1'b0);
    chk("mid_rst_ovf",  bus_a.overflow, 1'b0);
    chk("mid_rst_seg",  bus_a.segmentos, 56'd0);
    chk("mid_rst_segc", bus_c.segmentos, {56{1'b1}});
    @(negedge clock); reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (bus_a.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_conv(32'd12345678, 1'b0, lat, bcnt);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_seg", bus_a.segmentos, seg_12345678);

    // start held high retriggers every WIDTH+2 cycles
    @(negedge clock);
    start = 1'b1; binario = 32'd7; sm = 1'b0;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (bus_a.done) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    start = 1'b0;
    chk("cont_first", t1, 34);
    chk("cont_period", t2 - t1, 34);
    repeat (40) @(posedge clock);

    // randomized operands against the model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 999));
        1:       rb = $urandom();
        2:       rb = 32'd99999990 + 32'($urandom_range(0, 20));
        3:       rb = 32'd0 - 32'($urandom_range(1, 5000));
        default: rb = 32'h80000000 | 32'($urandom_range(0, 100));
      endcase
      rs = 1'($urandom_range(0, 1));
      run_conv(rb, rs, lat, bcnt);
      chk("rnd_lat", lat, 33);
      check_all(rb, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
